// File: rtl/start_light_seq.sv
// start_light_seq: start-light sequencer. A trigger on a tick fills an
// N_LEDS-wide bar one lamp per tick while enabling the LFSR, then holds
// start_delay until time_out. Defining START_LIGHT_FALSE_START_EN compiles
// in false-start detection (FAULT state with a blinking bar).
module start_light_seq #(
  parameter int unsigned N_LEDS         = 10,
  parameter bit          FILL_MSB_FIRST = 1'b1,
  parameter int unsigned FAULT_TICKS    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              trigger,
  input  logic              time_out,
  input  logic              react,
  output logic              en_lfsr,
  output logic              start_delay,
  output logic [N_LEDS-1:0] led,
  output logic              busy,
  output logic              done,
  output logic              false_start
);

  localparam int unsigned     CW       = $clog2(N_LEDS + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(N_LEDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_HOLD
`ifdef START_LIGHT_FALSE_START_EN
    , S_FAULT
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [N_LEDS-1:0] led_fill;

`ifdef START_LIGHT_FALSE_START_EN
  localparam logic [7:0] FAULT_LAST = 8'(FAULT_TICKS);
  logic [7:0] fcnt_q, fcnt_d;
  logic       blink_q, blink_d;
`else
  localparam int unsigned unused_fault_ticks = FAULT_TICKS;
  logic unused_react;
  always_comb unused_react = react;
`endif

  // State, lamp counter and registered done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef START_LIGHT_FALSE_START_EN
      fcnt_q  <= '0;
      blink_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef START_LIGHT_FALSE_START_EN
      fcnt_q  <= fcnt_d;
      blink_q <= blink_d;
`endif
    end
  end

  // Next-state logic; react takes priority over tick and time_out
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef START_LIGHT_FALSE_START_EN
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (trigger && tick) begin
          state_d = S_FILL;
          cnt_d   = CW'(1);
        end
      end
      S_FILL: begin
`ifdef START_LIGHT_FALSE_START_EN
        if (react) begin
          state_d = S_FAULT;
          cnt_d   = '0;
          fcnt_d  = '0;
          blink_d = 1'b1;
        end else
`endif
        if (tick) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CNT_FULL) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
`ifdef START_LIGHT_FALSE_START_EN
        if (react) begin
          state_d = S_FAULT;
          cnt_d   = '0;
          fcnt_d  = '0;
          blink_d = 1'b1;
        end else
`endif
        if (time_out) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
`ifdef START_LIGHT_FALSE_START_EN
      S_FAULT: begin
        if (tick) begin
          fcnt_d  = fcnt_q + 8'd1;
          blink_d = ~blink_q;
          if (fcnt_d == FAULT_LAST) state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Thermometer code of cnt lamps anchored at the selected end of the bar
  always_comb begin
    led_fill = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (FILL_MSB_FIRST) led_fill[i] = (i + 32'(cnt_q)) >= N_LEDS;
      else                led_fill[i] = i < 32'(cnt_q);
    end
  end

  // Moore output decode from registered state
  always_comb begin
    led         = '0;
    en_lfsr     = 1'b0;
    start_delay = 1'b0;
    false_start = 1'b0;
    busy        = (state_q != S_IDLE);
    done        = done_q;
    case (state_q)
      S_FILL: begin
        led     = led_fill;
        en_lfsr = 1'b1;
      end
      S_HOLD: begin
        led         = '1;
        start_delay = 1'b1;
      end
`ifdef START_LIGHT_FALSE_START_EN
      S_FAULT: begin
        led         = blink_q ? '1 : '0;
        false_start = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_start_light_seq.sv
// Bench for start_light_seq: two instances (10 lamps MSB-first, 4 lamps
// LSB-first) share stimulus; a behavioural model predicts every output.
module tb_start_light_seq;

`ifdef START_LIGHT_FALSE_START_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  localparam int FT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, trigger = 1'b0, tick = 1'b0, time_out = 1'b0, react = 1'b0;

  logic       en_a, sd_a, busy_a, done_a, fs_a;
  logic [9:0] led_a;
  logic       en_b, sd_b, busy_b, done_b, fs_b;
  logic [3:0] led_b;

  start_light_seq #(.N_LEDS(10), .FILL_MSB_FIRST(1'b1), .FAULT_TICKS(FT)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .time_out(time_out),
    .react(react), .en_lfsr(en_a), .start_delay(sd_a), .led(led_a),
    .busy(busy_a), .done(done_a), .false_start(fs_a));

  start_light_seq #(.N_LEDS(4), .FILL_MSB_FIRST(1'b0), .FAULT_TICKS(FT)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .time_out(time_out),
    .react(react), .en_lfsr(en_b), .start_delay(sd_b), .led(led_b),
    .busy(busy_b), .done(done_b), .false_start(fs_b));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: mode 0 idle, 1 filling, 2 holding, 3 fault
  int mode[2] = '{0, 0};
  int lit[2]  = '{0, 0};
  int fc[2]   = '{0, 0};
  bit on[2]   = '{1'b0, 1'b0};
  bit dn[2]   = '{1'b0, 1'b0};

  function automatic int nleds(int k);
    return (k == 0) ? 10 : 4;
  endfunction

  function automatic logic [31:0] exp_led(int k);
    logic [63:0] ones;
    int n;
    n = nleds(k);
    case (mode[k])
      1: begin
        ones = (64'd1 << lit[k]) - 64'd1;
        if (k == 0) ones = ones << (n - lit[k]);
        return ones[31:0];
      end
      2: begin
        ones = (64'd1 << n) - 64'd1;
        return ones[31:0];
      end
      3: begin
        ones = on[k] ? (64'd1 << n) - 64'd1 : 64'd0;
        return ones[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      dn[k] = 1'b0;
      if (rst) begin
        mode[k] = 0; lit[k] = 0; fc[k] = 0; on[k] = 1'b0;
      end else begin
        case (mode[k])
          0: if (trigger && tick) begin mode[k] = 1; lit[k] = 1; end
          1: begin
            if (FE && react) begin mode[k] = 3; fc[k] = 0; on[k] = 1'b1; end
            else if (tick) begin
              lit[k] = lit[k] + 1;
              if (lit[k] == nleds(k)) mode[k] = 2;
            end
          end
          2: begin
            if (FE && react) begin mode[k] = 3; fc[k] = 0; on[k] = 1'b1; end
            else if (time_out) begin mode[k] = 0; lit[k] = 0; dn[k] = 1'b1; end
          end
          default: begin
            if (tick) begin
              fc[k] = fc[k] + 1;
              on[k] = !on[k];
              if (fc[k] == FT) begin mode[k] = 0; lit[k] = 0; end
            end
          end
        endcase
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a_led",   {22'd0, led_a}, exp_led(0));
    check("a_en",    {31'd0, en_a},   {31'd0, mode[0] == 1});
    check("a_sd",    {31'd0, sd_a},   {31'd0, mode[0] == 2});
    check("a_busy",  {31'd0, busy_a}, {31'd0, mode[0] != 0});
    check("a_done",  {31'd0, done_a}, {31'd0, dn[0]});
    check("a_fs",    {31'd0, fs_a},   {31'd0, mode[0] == 3});
    check("b_led",   {28'd0, led_b}, exp_led(1));
    check("b_en",    {31'd0, en_b},   {31'd0, mode[1] == 1});
    check("b_sd",    {31'd0, sd_b},   {31'd0, mode[1] == 2});
    check("b_busy",  {31'd0, busy_b}, {31'd0, mode[1] != 0});
    check("b_done",  {31'd0, done_b}, {31'd0, dn[1]});
    check("b_fs",    {31'd0, fs_b},   {31'd0, mode[1] == 3});
  endtask

  // apply inputs, clock one edge, update model, check outputs 1 time unit later
  task automatic cycle(input bit r, input bit tr, input bit tk, input bit to, input bit re);
    rst = r; trigger = tr; tick = tk; time_out = to; react = re;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check_all();
  endtask

  initial begin
    // reset and trigger without tick
    repeat (2) cycle(1, 0, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0, 0);

    // normal fill, tick every 4 cycles; time_out early, trigger and ticks in hold
    cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, (i < 5) && (i % 2 == 1), 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
    end
    cycle(0, 0, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);

    // reset held 3 cycles mid-fill
    cycle(0, 1, 1, 0, 0);
    repeat (4) begin cycle(0, 0, 0, 0, 0); cycle(0, 0, 1, 0, 0); end
    repeat (3) cycle(1, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);

    // react together with a tick at cnt = 5, then keep ticking
    cycle(0, 1, 1, 0, 0);
    repeat (4) begin cycle(0, 0, 0, 0, 0); cycle(0, 0, 1, 0, 0); end
    cycle(0, 0, 1, 0, 1);
    repeat (8) begin cycle(0, 0, 0, 0, 0); cycle(0, 0, 1, 0, 0); end
    cycle(0, 0, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);

    // react pulses throughout a full sequence
    cycle(0, 1, 1, 0, 1);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, 0, i % 3 == 0);
      cycle(0, 0, 1, 0, 0);
    end
    cycle(0, 0, 0, 1, 1);
    repeat (2) cycle(0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
            $urandom_range(7) == 0, $urandom_range(15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
